// File: rtl/modadd_scheduler.sv
// Round-robin scheduler sharing one combinational mod-15 adder between two requesters.
// Each accepted op holds the adder operands for SETTLE cycles, then returns z over valid/ready.
module modadd_scheduler #(
  parameter int SETTLE    = 2,
  parameter bit NORMALIZE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_s,
  input  logic [3:0] req0_x,
  input  logic [3:0] req0_y,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_s,
  input  logic [3:0] req1_x,
  input  logic [3:0] req1_y,
  output logic       add_s,
  output logic [3:0] add_x,
  output logic [3:0] add_y,
  input  logic [3:0] add_z,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_z,
  output logic       busy
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  typedef struct packed {
    logic       s;
    logic [3:0] x;
    logic [3:0] y;
    logic       id;
  } op_t;

  state_t        state, state_nxt;
  logic          rr_ptr;
  logic [CW-1:0] cnt;
  op_t           op;
  logic [1:0]    vld;
  logic          gnt, gnt_id;
  op_t           gnt_op;

  assign vld = {req1_valid, req0_valid};

  always_comb begin
    state_nxt  = state;
    gnt        = 1'b0;
    gnt_id     = vld[rr_ptr] ? rr_ptr : ~rr_ptr;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    gnt_op     = gnt_id ? '{s: req1_s, x: req1_x, y: req1_y, id: 1'b1}
                        : '{s: req0_s, x: req0_x, y: req0_y, id: 1'b0};
    case (state)
      IDLE: if (|vld) begin
        gnt        = 1'b1;
        req0_ready = ~gnt_id;
        req1_ready = gnt_id;
        state_nxt  = EXEC;
      end
      EXEC: if (cnt == '0) state_nxt = HOLD;
      HOLD: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Adder operands come straight from the op register, so they stay at the last op
  assign add_s     = op.s;
  assign add_x     = op.x;
  assign add_y     = op.y;
  assign rsp_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      cnt    <= '0;
      op     <= '0;
      rsp_z  <= 4'h0;
      rsp_id <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt) begin
        op     <= gnt_op;
        rr_ptr <= ~gnt_id;
        cnt    <= CW'(SETTLE - 1);
      end
      if (state == EXEC) begin
        if (cnt == '0) begin
          // 4'hF is the adder's negative zero
          rsp_z  <= (NORMALIZE && add_z == 4'hF) ? 4'h0 : add_z;
          rsp_id <= op.id;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_modadd_scheduler.sv
// Bench for modadd_scheduler: a one's-complement adder feeds two instances
// (NORMALIZE=1 and 0); a transaction-level model is checked every cycle.
module tb_modadd_scheduler;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       r0v, r0s, r1v, r1s, rsp_ready;
  logic [3:0] r0x, r0y, r1x, r1y;
  logic       r0r, r1r, add_s, rsp_valid, rsp_id, busy;
  logic [3:0] add_x, add_y, add_z, rsp_z;
  logic       n_r0r, n_r1r, n_add_s, n_rsp_valid, n_rsp_id, n_busy;
  logic [3:0] n_add_x, n_add_y, n_add_z, n_rsp_z;

  int total = 0;
  int bad   = 0;

  function automatic logic [3:0] ocadd(input logic s, input logic [3:0] x, input logic [3:0] y);
    logic [4:0] t;
    t = {1'b0, x} + {1'b0, (s ? ~y : y)};
    return t[3:0] + {3'b000, t[4]};
  endfunction

  assign add_z   = ocadd(add_s, add_x, add_y);
  assign n_add_z = ocadd(n_add_s, n_add_x, n_add_y);

  modadd_scheduler #(.SETTLE(SETTLE), .NORMALIZE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(r0r), .req0_s(r0s), .req0_x(r0x), .req0_y(r0y),
    .req1_valid(r1v), .req1_ready(r1r), .req1_s(r1s), .req1_x(r1x), .req1_y(r1y),
    .add_s(add_s), .add_x(add_x), .add_y(add_y), .add_z(add_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .busy(busy));

  modadd_scheduler #(.SETTLE(SETTLE), .NORMALIZE(1'b0)) dut_n0 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(n_r0r), .req0_s(r0s), .req0_x(r0x), .req0_y(r0y),
    .req1_valid(r1v), .req1_ready(n_r1r), .req1_s(r1s), .req1_x(r1x), .req1_y(r1y),
    .add_s(n_add_s), .add_x(n_add_x), .add_y(n_add_y), .add_z(n_add_z),
    .rsp_valid(n_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(n_rsp_id), .rsp_z(n_rsp_z),
    .busy(n_busy));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Transaction model: one op in flight, result due SETTLE+1 cycles after acceptance
  int         cyc   = 0;
  bit         m_inf = 1'b0;
  int         m_acc = 0;
  bit         m_rr  = 1'b0;
  bit         m_id  = 1'b0;
  logic       m_s   = 1'b0;
  logic [3:0] m_x   = 4'h0;
  logic [3:0] m_y   = 4'h0;
  int         m_z   = 0;
  int         m_raw = 0;

  always @(negedge clk) begin
    bit ev, g, e0, e1, any;
    int tx, ty;
    any = r0v || r1v;
    ev  = m_inf && (cyc >= m_acc + SETTLE + 1);
    g   = (m_rr ? r1v : r0v) ? m_rr : !m_rr;
    e0  = !m_inf && any && !g;
    e1  = !m_inf && any && g;
    chk("m_busy", busy, m_inf);
    chk("m_rsp_valid", rsp_valid, ev);
    chk("m_n0_rsp_valid", n_rsp_valid, ev);
    chk("m_req0_ready", r0r, e0);
    chk("m_req1_ready", r1r, e1);
    chk("m_add_s", add_s, m_s);
    chk("m_add_x", add_x, m_x);
    chk("m_add_y", add_y, m_y);
    if (ev) begin
      chk("m_rsp_z", rsp_z, m_z);
      chk("m_rsp_id", rsp_id, m_id);
      chk("m_n0_rsp_z", n_rsp_z, m_raw);
    end
    if (rst) begin
      m_inf = 1'b0; m_rr = 1'b0; m_s = 1'b0; m_x = 4'h0; m_y = 4'h0;
    end else if (e0 || e1) begin
      m_inf = 1'b1; m_acc = cyc; m_id = g; m_rr = !g;
      m_s = g ? r1s : r0s;
      m_x = g ? r1x : r0x;
      m_y = g ? r1y : r0y;
      tx = int'(m_x); ty = int'(m_y);
      m_z   = m_s ? (tx + 15 - ty) % 15 : (tx + ty) % 15;
      m_raw = (m_z == 0 && (m_s || tx + ty != 0)) ? 15 : m_z;
    end else if (ev && rsp_ready) begin
      m_inf = 1'b0;
    end
    cyc++;
  end

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 40);
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  task automatic do_op(input bit id, input bit s, input logic [3:0] x, input logic [3:0] y,
                       input logic [3:0] ez, input logic [3:0] raw);
    int n;
    @(posedge clk); #1;
    if (id) begin r1v = 1; r1s = s; r1x = x; r1y = y; end
    else    begin r0v = 1; r0s = s; r0x = x; r0y = y; end
    rsp_ready = 1;
    @(negedge clk);
    chk("grant_ready", id ? r1r : r0r, 1);
    @(posedge clk); #1;
    r0v = 0; r1v = 0;
    wait_rsp(n);
    chk("latency", n, SETTLE + 1);
    chk("op_rsp_z", rsp_z, ez);
    chk("op_rsp_id", rsp_id, id);
    chk("op_n0_rsp_z", n_rsp_z, raw);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ng;
    int gl [4];
    int ge [4];
    bit ok;
    r0v = 0; r0s = 0; r0x = 0; r0y = 0;
    r1v = 0; r1s = 0; r1x = 0; r1y = 0;
    rsp_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_z", rsp_z, 0);
    chk("rst_add_x", add_x, 0);
    @(posedge clk); #1 rst = 0;

    do_op(0, 0, 4'd9, 4'd8, 4'd2, 4'd2);
    do_op(0, 0, 4'd7, 4'd8, 4'd0, 4'd15);
    do_op(1, 1, 4'd3, 4'd7, 4'd11, 4'd11);
    do_op(1, 1, 4'd5, 4'd5, 4'd0, 4'd15);

    // both valid continuously: alternate grants
    @(posedge clk); #1;
    r0v = 1; r0s = 0; r0x = 4'd1; r0y = 4'd2;
    r1v = 1; r1s = 0; r1x = 4'd4; r1y = 4'd4;
    rsp_ready = 1;
    ng = 0; ok = 1;
    ge = '{0, 1, 0, 1};
    for (int k = 0; k < 40 && ng < 4; k++) begin
      @(negedge clk);
      if (r0r)       begin gl[ng] = 0; ng++; end
      else if (r1r)  begin gl[ng] = 1; ng++; end
      else if (!busy) ok = 0;
    end
    chk("rr_grant_count", ng, 4);
    for (int i = 0; i < 4; i++) chk("rr_grant_order", gl[i], ge[i]);
    chk("rr_busy_between", ok, 1);
    @(posedge clk); #1;
    r0v = 0; r1v = 0;
    wait_rsp(n);
    chk("rr_last_latency", n, SETTLE + 1);
    chk("rr_last_z", rsp_z, 8);

    // backpressure
    @(posedge clk); #1;
    r1v = 1; r1s = 1; r1x = 4'd2; r1y = 4'd9;
    rsp_ready = 0;
    @(negedge clk);
    chk("bp_grant", r1r, 1);
    @(posedge clk); #1;
    r1v = 0; r0v = 1; r0s = 0; r0x = 4'd6; r0y = 4'd6;
    wait_rsp(n);
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_z != 4'd8 || rsp_id != 1'b1 || r0r || r1r || !rsp_valid) ok = 0;
    end
    chk("bp_stable", ok, 1);
    chk("bp_rsp_z", rsp_z, 8);
    @(posedge clk); #1;
    rsp_ready = 1; r0v = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_busy", busy, 0);

    // reset during EXEC, then a tie goes to req0
    @(posedge clk); #1;
    r0v = 1; r0s = 0; r0x = 4'd3; r0y = 4'd3;
    @(negedge clk);
    chk("rst_test_grant", r0r, 1);
    @(posedge clk); #1;
    r0v = 0; rst = 1;
    @(negedge clk);
    chk("exec_busy", busy, 1);
    @(posedge clk); #1;
    rst = 0;
    r0v = 1; r0s = 0; r0x = 4'd1; r0y = 4'd1;
    r1v = 1; r1s = 0; r1x = 4'd2; r1y = 4'd2;
    @(negedge clk);
    chk("post_rst_valid", rsp_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_tie_req0", r0r, 1);
    chk("post_rst_tie_req1", r1r, 0);
    @(posedge clk); #1;
    r0v = 0; r1v = 0;
    wait_rsp(n);
    chk("post_rst_z", rsp_z, 2);
    chk("post_rst_id", rsp_id, 0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
